dac_frame_sequencer: RTL and testbench

//  Upstream of the DAC SPI serialiser. On each sample_tick, snapshots up to four 16-bit

---
 rtl/dac_pkg.sv | 41 ++++
 rtl/dac_frame_sequencer.sv | 118 +++++++++++
 tb/tb_dac_frame_sequencer.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/dac_pkg.sv
// Shared definitions for the DAC frame sequencer: command-word layout, load codes,
// FSM states and the word-builder helper.
package dac_pkg;

    localparam int DAC_WORD_W = 24;
    localparam int SAMPLE_W   = 16;

    localparam int ADDR_LSB = 22;
    localparam int LD_LSB   = 20;
    localparam int CH_LSB   = 17;
    localparam int PD_BIT   = 16;

    localparam logic [1:0] LD_BUFFER     = 2'b00;
    localparam logic [1:0] LD_UPDATE_ALL = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_WAIT
    } state_t;

    // Offset-binary conversion is just an MSB flip of the two's complement sample.
    function automatic logic [DAC_WORD_W-1:0] dac_word(
        input logic [1:0]          ch,
        input logic [1:0]          ld,
        input logic [SAMPLE_W-1:0] sample,
        input logic                signed_in
    );
        logic [DAC_WORD_W-1:0] w;
        w                        = '0;
        w[ADDR_LSB+1:ADDR_LSB]   = 2'b00;
        w[LD_LSB+1:LD_LSB]       = ld;
        w[CH_LSB+1:CH_LSB]       = ch;
        w[PD_BIT]                = 1'b0;
        w[SAMPLE_W-1:0]          = signed_in ? {~sample[SAMPLE_W-1], sample[SAMPLE_W-2:0]}
                                             : sample;
        return w;
    endfunction

endpackage

// File: rtl/dac_frame_sequencer.sv
// Snapshots up to four channel samples per sample_tick and issues one DAC command word
// per enabled channel, spaced so each SPI transfer finishes before the next send.
module dac_frame_sequencer
    import dac_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int SEND_GAP  = 540,
    parameter int SIGNED_IN = 1
) (
    input  logic                         clock_in,
    input  logic                         reset_n,
    input  logic                         sample_tick,
    input  logic [SAMPLE_W*NUM_CH-1:0]   ch_data,
    input  logic [NUM_CH-1:0]            ch_enable,
    input  logic                         clear_overrun,
    output logic [DAC_WORD_W-1:0]        data_out,
    output logic                         send,
    output logic                         busy,
    output logic                         overrun
);

    localparam int GAP_W = $clog2(SEND_GAP + 1);

    state_t                state, state_nxt;
    logic [SAMPLE_W-1:0]   snap [NUM_CH];
    logic [NUM_CH-1:0]     pend;
    logic [1:0]            cur_ch;
    logic [GAP_W-1:0]      gap_cnt;
    logic                  gap_done;
    logic                  accept;
    logic                  set_ovr;

    // Lowest set bit wins; channels at or above NUM_CH have no mask bit and are never chosen.
    function automatic logic [1:0] lowest(input logic [NUM_CH-1:0] m);
        logic [1:0] idx;
        idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (m[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    function automatic logic [NUM_CH-1:0] drop(input logic [NUM_CH-1:0] m, input logic [1:0] idx);
        return m & ~(NUM_CH'(1) << idx);
    endfunction

    assign gap_done = (gap_cnt == GAP_W'(SEND_GAP - 1));

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (sample_tick && (|ch_enable)) begin
                    accept    = 1'b1;
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: state_nxt = ST_SEND;
            ST_SEND: state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (gap_done) state_nxt = (pend != '0) ? ST_LOAD : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Any tick outside IDLE is lost, including the one landing on the WAIT->IDLE edge.
    assign set_ovr = sample_tick && (state != ST_IDLE);

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) snap[i] <= '0;
            pend     <= '0;
            cur_ch   <= '0;
            gap_cnt  <= '0;
            data_out <= '0;
            send     <= 1'b0;
            busy     <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            send <= (state == ST_SEND);
            busy <= (state_nxt != ST_IDLE);

            if (set_ovr)            overrun <= 1'b1;
            else if (clear_overrun) overrun <= 1'b0;

            if (accept) begin
                for (int i = 0; i < NUM_CH; i++) snap[i] <= ch_data[i*SAMPLE_W +: SAMPLE_W];
                cur_ch <= lowest(ch_enable);
                pend   <= drop(ch_enable, lowest(ch_enable));
            end

            // An empty remaining mask means this is the frame's last word.
            if (state == ST_LOAD) begin
                data_out <= dac_word(cur_ch, (pend == '0) ? LD_UPDATE_ALL : LD_BUFFER,
                                     snap[cur_ch], SIGNED_IN != 0);
            end

            if (state == ST_SEND)      gap_cnt <= '0;
            else if (state == ST_WAIT) gap_cnt <= gap_cnt + GAP_W'(1);

            if ((state == ST_WAIT) && gap_done && (pend != '0)) begin
                cur_ch <= lowest(pend);
                pend   <= drop(pend, lowest(pend));
            end
        end
    end

endmodule

// File: tb/tb_dac_frame_sequencer.sv
// Directed bench: stimulus pushes expected words and send cycles into a queue; a
// negedge monitor pops and compares each send.
module tb_dac_frame_sequencer;
    localparam int NUM_CH = 4;
    localparam int GAP    = 540;
    localparam int PER    = GAP + 2;

    typedef struct {
        logic [23:0] word;
        int          cyc;
    } exp_t;

    logic                 clock_in = 1'b0;
    logic                 reset_n  = 1'b0;
    logic                 sample_tick = 1'b0;
    logic [16*NUM_CH-1:0] ch_data = '0;
    logic [NUM_CH-1:0]    ch_enable = '0;
    logic                 clear_overrun = 1'b0;
    logic [23:0]          data_out;
    logic                 send, busy, overrun;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t q[$];

    dac_frame_sequencer #(.NUM_CH(NUM_CH), .SEND_GAP(GAP), .SIGNED_IN(1)) dut (
        .clock_in(clock_in), .reset_n(reset_n), .sample_tick(sample_tick),
        .ch_data(ch_data), .ch_enable(ch_enable), .clear_overrun(clear_overrun),
        .data_out(data_out), .send(send), .busy(busy), .overrun(overrun)
    );

    always #5 clock_in = ~clock_in;
    always @(posedge clock_in) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clock_in) begin
        if (send === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_send", 32'(data_out), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("word", 32'(data_out), 32'(e.word));
                chk("send_cyc", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clock_in);
    endtask

    task automatic push(input logic [23:0] w, input int c);
        exp_t e;
        e.word = w;
        e.cyc  = c;
        q.push_back(e);
    endtask

    // Called at a negedge; returns the cycle stamp the tick was driven in.
    task automatic tick(output int c);
        c = cyc;
        sample_tick = 1'b1;
        @(negedge clock_in);
        sample_tick = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        repeat (3) @(negedge clock_in);
        chk("rst_send", 32'(send), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_data", 32'(data_out), 0);
        chk("rst_ovr", 32'(overrun), 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clock_in);

        // All enables off: tick ignored.
        ch_enable = 4'b0000;
        tick(c);
        @(negedge clock_in);
        chk("zero_en_busy", 32'(busy), 0);
        chk("zero_en_ovr", 32'(overrun), 0);

        // Single channel, then a tick exactly on the WAIT->IDLE edge.
        ch_data   = {16'h0, 16'h0, 16'h0, 16'h8000};
        ch_enable = 4'b0001;
        tick(c);
        push(24'h200000, c + 3);
        chk("single_busy", 32'(busy), 1);
        wait_cyc(c + PER);
        chk("single_busy_end", 32'(busy), 1);
        tick(c);
        chk("single_busy_low", 32'(busy), 0);
        chk("edge_tick_ovr", 32'(overrun), 1);
        repeat (10) @(negedge clock_in);
        chk("edge_tick_dropped", 32'(busy), 0);
        clear_overrun = 1'b1;
        @(negedge clock_in);
        clear_overrun = 1'b0;
        chk("clear_ovr", 32'(overrun), 0);

        // Full frame.
        ch_data   = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        ch_enable = 4'b1111;
        tick(c);
        push(24'h009111, c + 3);
        push(24'h02A222, c + 3 + PER);
        push(24'h04B333, c + 3 + 2*PER);
        push(24'h26C444, c + 3 + 3*PER);
        wait_cyc(c + 4*PER);
        chk("full_busy_end", 32'(busy), 1);
        @(negedge clock_in);
        chk("full_busy_low", 32'(busy), 0);
        chk("full_ovr", 32'(overrun), 0);

        // Sparse frame with inputs changed mid-frame.
        ch_data   = {16'hFFFF, 16'h5555, 16'h0123, 16'hAAAA};
        ch_enable = 4'b1010;
        tick(c);
        push(24'h028123, c + 3);
        push(24'h267FFF, c + 3 + PER);
        wait_cyc(c + 50);
        ch_data   = '0;
        ch_enable = 4'b1111;
        wait_cyc(c + 2*PER + 5);
        chk("sparse_busy_low", 32'(busy), 0);

        // Overrun set, clear, and simultaneous set/clear.
        ch_data   = {16'h0, 16'h0, 16'h0000, 16'h7FFF};
        ch_enable = 4'b0011;
        tick(c);
        push(24'h00FFFF, c + 3);
        push(24'h228000, c + 3 + PER);
        wait_cyc(c + 100);
        begin
            int c2;
            tick(c2);
        end
        chk("ovr_set", 32'(overrun), 1);
        wait_cyc(c + 200);
        clear_overrun = 1'b1;
        @(negedge clock_in);
        clear_overrun = 1'b0;
        chk("ovr_clear", 32'(overrun), 0);
        wait_cyc(c + 300);
        clear_overrun = 1'b1;
        begin
            int c2;
            tick(c2);
        end
        clear_overrun = 1'b0;
        chk("ovr_set_wins", 32'(overrun), 1);
        wait_cyc(c + 2*PER + 5);
        chk("ovr_frame_done", 32'(busy), 0);
        chk("ovr_sticky", 32'(overrun), 1);
        clear_overrun = 1'b1;
        @(negedge clock_in);
        clear_overrun = 1'b0;

        // Reset mid-WAIT abandons the frame.
        ch_data   = {16'h1234, 16'h0, 16'h5678, 16'h0};
        ch_enable = 4'b1010;
        tick(c);
        push(24'h02D678, c + 3);
        wait_cyc(c + 200);
        #1 reset_n = 1'b0;
        q.delete();
        #1;
        chk("midrst_send", 32'(send), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_data", 32'(data_out), 0);
        chk("midrst_ovr", 32'(overrun), 0);
        repeat (3) @(negedge clock_in);
        reset_n = 1'b1;
        repeat (1200) @(negedge clock_in);
        chk("postrst_busy", 32'(busy), 0);

        chk("queue_empty", 32'(q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
